multiplication_division_unit: RTL and testbench
===============================================

MULTIPLICATION_DIVISION_UNIT -- requirements
Module: multiplication_division_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 A  input  32  operand rs (dividend / multiplicand / mthi/mtlo source).
REQ-006 B  input  32  operand rt (divisor / multiplier).
REQ-007 op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 start  input  1  single-cycle request qualifying op.
REQ-009 busy  output  1  operation in flight; the controller SHALL stall HI/LO consumers and new MDU ops while busy or start is high.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, a down-counter wide enough for max(MUL_CYCLES, DIV_CYCLES), and pending-result registers pend_hi/pend_lo.
REQ-013 IDLE, start=1, op in {mult, multu, div, divu} at edge T0: compute the result from A/B sampled at T0 into pend_hi/pend_lo, load the counter with the op's cycle count, enter BUSY.
REQ-014 busy SHALL be 1 from immediately after T0 until edge TN (N = MUL_CYCLES or DIV_CYCLES), i.e. high for exactly N cycles; it SHALL drop at TN.
REQ-015 At TN, hi<=pend_hi and lo<=pend_lo in the same edge that busy falls; hi/lo SHALL hold their old values throughout BUSY.
REQ-016 mult: {hi,lo} = signed 64-bit A*B; multu: unsigned 64-bit A*B.
REQ-017 div: lo = signed quotient truncated toward zero, hi = remainder with the sign of A; divu: unsigned quotient/remainder.
REQ-018 Divide by zero (div or divu, B=0): lo=0xFFFFFFFF, hi=A.
REQ-019 Signed overflow (div, A=0x80000000, B=0xFFFFFFFF): lo=0x80000000, hi=0x00000000.
REQ-020 IDLE, start=1, op=mthi: hi<=A at that edge, lo unchanged, busy stays 0; op=mtlo: lo<=A, hi unchanged.
REQ-021 IDLE, start=1, op none/reserved: no state change.
REQ-022 start while BUSY (any op, including mthi/mtlo, and including the edge TN) SHALL be ignored with no effect on counter, pending results, hi, or lo.
REQ-023 start asserted in the first cycle after TN (busy=0) SHALL be accepted normally; back-to-back operations lose no cycles beyond N.
REQ-024 busy SHALL be a registered output, never combinationally dependent on start or op.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=IDLE, busy=0, counter=0, hi=0, lo=0, pend_hi=0, pend_lo=0.
REQ-026 Reset asserted mid-operation SHALL abort it; no commit to hi/lo occurs after reset_n rises.
REQ-027 The first rising edge with reset_n=1 SHALL accept start normally.

Verification
REQ-028 mult A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during busy.
REQ-029 multu A=0xFFFFFFFF B=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-030 div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-031 div A=5 B=0 -> lo=0xFFFFFFFF, hi=0x00000005; div A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 mthi A=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0; mtlo and mult issued mid-BUSY -> ignored, original result commits unchanged.
REQ-033 reset_n pulsed low in cycle 3 of a div -> busy, hi, lo read 0 immediately; no commit afterward; new mult after release completes in 5 cycles.

Source files
------------

// File: rtl/multiplication_division_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Results are computed at issue and committed after a fixed latency.
module multiplication_division_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC =
        (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   pend_hi, pend_hi_nx;
    logic [31:0]   pend_lo, pend_lo_nx;
    logic [31:0]   hi_nx, lo_nx;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, bu_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] sq, sr, uq, ur;
    logic [31:0] res_hi, res_lo;

    // Arithmetic results from the operands presented this cycle
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        a_mag   = A[31] ? (32'd0 - A) : A;
        b_mag   = B[31] ? (32'd0 - B) : B;
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        bu_safe = (B == 32'd0) ? 32'd1 : B;
        // Magnitude division; 0x80000000 / 1 wraps back to the overflow value
        q_mag   = a_mag / b_safe;
        r_mag   = a_mag % b_safe;
        sq      = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        sr      = A[31] ? (32'd0 - r_mag) : r_mag;
        uq      = A / bu_safe;
        ur      = A % bu_safe;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        unique case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi = sr;
                res_lo = sq;
            end
            OP_DIVU: begin
                res_hi = ur;
                res_lo = uq;
            end
            default: ;
        endcase
        if ((op == OP_DIV || op == OP_DIVU) && B == 32'd0) begin
            res_hi = A;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    // Next-state, counter, pending and architectural register updates
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_hi_nx = pend_hi;
        pend_lo_nx = pend_lo;
        hi_nx      = hi;
        lo_nx      = lo;
        unique case (state)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_nx = res_hi;
                            pend_lo_nx = res_lo;
                            cnt_nx     = CW'(MUL_CYCLES);
                            state_nx   = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_nx = res_hi;
                            pend_lo_nx = res_lo;
                            cnt_nx     = CW'(DIV_CYCLES);
                            state_nx   = BUSY;
                        end
                        OP_MTHI: hi_nx = A;
                        OP_MTLO: lo_nx = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt <= CW'(1)) begin
                    hi_nx    = pend_hi;
                    lo_nx    = pend_lo;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and data registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_hi <= pend_hi_nx;
            pend_lo <= pend_lo_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_multiplication_division_unit.sv
// Scoreboard bench for multiplication_division_unit.
// Expected HI/LO come from a plain-arithmetic reference model.
module tb_multiplication_division_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  op = 3'd0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    multiplication_division_unit #(
        .MUL_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .A(A),
        .B(B),
        .op(op),
        .start(start),
        .busy(busy),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {hi, lo} after the op, from architectural rules
    function automatic logic [63:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] ch,
                                            input logic [31:0] cl);
        longint          x, y, q, r;
        longint unsigned ux, uy;
        logic [63:0]     v;
        v = {ch, cl};
        case (o)
            3'd1: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                v = 64'(x * y);
            end
            3'd2: begin
                ux = longint'(a);
                uy = longint'(b);
                v = ux * uy;
            end
            3'd3: begin
                if (b == 0) begin
                    v = {a, 32'hFFFF_FFFF};
                end else begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    q = x / y;
                    r = x % y;
                    v = {32'(r), 32'(q)};
                end
            end
            3'd4: begin
                if (b == 0) v = {a, 32'hFFFF_FFFF};
                else v = {a % b, a / b};
            end
            3'd5: v = {a, cl};
            3'd6: v = {ch, a};
            default: v = {ch, cl};
        endcase
        return v;
    endfunction

    // Monitor: hold check while busy, pop and compare on busy fall
    logic prev_busy = 1'b0;
    int   bcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
            bcnt = 0;
        end else begin
            if (busy) begin
                bcnt++;
                check("hold_hi", 64'(hi), 64'(cur_hi));
                check("hold_lo", 64'(lo), 64'(cur_lo));
            end else begin
                if (prev_busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("busy_cycles", 64'(bcnt), 64'(e.cyc));
                        check("commit_hi", 64'(hi), 64'(e.hi));
                        check("commit_lo", 64'(lo), 64'(e.lo));
                        cur_hi = e.hi;
                        cur_lo = e.lo;
                    end
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Issue one op just after a negedge; returns at the negedge busy is low
    task automatic run_exp(input logic [2:0] o,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [63:0] ex,
                           input bit hammer);
        exp_t e;
        int   n;
        #1;
        A = a;
        B = b;
        op = o;
        start = 1'b1;
        if (o >= 3'd1 && o <= 3'd4) begin
            e.hi = ex[63:32];
            e.lo = ex[31:0];
            e.cyc = (o <= 3'd2) ? MC : DC;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            op = 3'd0;
            check("busy_rise", 64'(busy), 64'd1);
            n = 0;
            while (busy && n < 60) begin
                if (hammer) begin
                    start = 1'b1;
                    op = 3'($urandom_range(0, 7));
                    A = $urandom;
                    B = $urandom;
                end
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            op = 3'd0;
            if (busy) check("busy_timeout", 64'd1, 64'd0);
        end else begin
            @(negedge clk);
            start = 1'b0;
            op = 3'd0;
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_hi", 64'(hi), ex[63:32]);
            check("idle_lo", 64'(lo), 64'(ex[31:0]));
            cur_hi = ex[63:32];
            cur_lo = ex[31:0];
        end
    endtask

    task automatic run_op(input logic [2:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input bit hammer);
        #1;
        run_exp(o, a, b, ref_res(o, a, b, cur_hi, cur_lo), hammer);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset_n = 1'b1;

        run_exp(3'd1, 32'hFFFF_FFFF, 32'd2,
                {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b0);
        run_exp(3'd2, 32'hFFFF_FFFF, 32'd2,
                {32'h0000_0001, 32'hFFFF_FFFE}, 1'b0);
        run_exp(3'd3, 32'hFFFF_FFF9, 32'd2,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_exp(3'd4, 32'hFFFF_FFF9, 32'd2,
                {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0);
        run_exp(3'd3, 32'd5, 32'd0,
                {32'h0000_0005, 32'hFFFF_FFFF}, 1'b0);
        run_exp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h0000_0000, 32'h8000_0000}, 1'b0);
        run_exp(3'd5, 32'h1234_5678, 32'd0,
                {32'h1234_5678, 32'h8000_0000}, 1'b0);
        run_exp(3'd6, 32'hCAFE_F00D, 32'd0,
                {32'h1234_5678, 32'hCAFE_F00D}, 1'b0);
        run_exp(3'd0, 32'hDEAD_BEEF, 32'd0,
                {32'h1234_5678, 32'hCAFE_F00D}, 1'b0);
        run_exp(3'd7, 32'hDEAD_BEEF, 32'd0,
                {32'h1234_5678, 32'hCAFE_F00D}, 1'b0);
        run_exp(3'd1, 32'd7, 32'hFFFF_FFFD,
                {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1);

        // Reset in the third cycle of a divide
        #1;
        A = 32'd100;
        B = 32'd3;
        op = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_commit_busy", 64'(busy), 64'd0);
        check("no_commit_hi", 64'(hi), 64'd0);
        check("no_commit_lo", 64'(lo), 64'd0);
        run_exp(3'd1, 32'd6, 32'd7, {32'd0, 32'd42}, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
